// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the two-requester register bus arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int          ADDR_W_DEF    = 16;
    localparam int          DATA_W_DEF    = 32;
    localparam logic [31:0] TMO_RDATA_DEF = 32'hDEAD_BEEF;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reg_arb_tmo.sv
// Bus watchdog: counts cycles of an outstanding bus request and flags when
// the count has reached TIMEOUT. The counter saturates at TIMEOUT.
module reg_arb_tmo
    import reg_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Clear on a fresh grant, otherwise count while enabled up to the limit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter between the SPI command decoder (s0) and the local
// housekeeping sequencer (s1) for the internal register bus. One transaction
// in flight; a stalled slave is answered with a timeout response.
// Optional macro REG_ARB_LOCK_EN adds s0_lock/s1_lock so a requester can keep
// the bus across a burst of back-to-back transactions.
module reg_bus_arb
    import reg_arb_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] TMO_RDATA = TMO_RDATA_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_req,
    input  logic              s0_wr,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_wdata,
    output logic              s0_ack,
    output logic [DATA_W-1:0] s0_rdata,
    output logic              s0_err,
    input  logic              s1_req,
    input  logic              s1_wr,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic              s1_ack,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              s1_err,
`ifdef REG_ARB_LOCK_EN
    input  logic              s0_lock,
    input  logic              s1_lock,
`endif
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam logic [DATA_W-1:0] TMO_VAL = DATA_W'(TMO_RDATA);

    state_t            state, state_n;
    logic              last_grant;   // also identifies the owner of the current transaction
    logic              grant;
    logic              sel;
    logic              done;
    logic              tmo_clr, tmo_en, expired;
    logic              lock_hold;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    reg_arb_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (expired)
    );

`ifdef REG_ARB_LOCK_EN
    logic lock_q;

    // Capture the owner's lock request during the response cycle; any IDLE
    // cycle consumes or releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (state == RESP) begin
            lock_q <= last_grant ? s1_lock : s0_lock;
        end else if (state == IDLE) begin
            lock_q <= 1'b0;
        end
    end

    assign lock_hold = lock_q && (last_grant ? s1_req : s0_req);
`else
    assign lock_hold = 1'b0;
`endif

    // Next-state, arbitration and watchdog control.
    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        sel      = last_grant;
        done     = 1'b0;
        tmo_clr  = 1'b0;
        tmo_en   = 1'b0;
        rsp_err  = !m_ack;
        rsp_data = m_wr ? '0 : (m_ack ? m_rdata : TMO_VAL);
        case (state)
            IDLE: begin
                if (s0_req || s1_req) begin
                    grant   = 1'b1;
                    tmo_clr = 1'b1;
                    state_n = GRANT;
                    if (lock_hold)            sel = last_grant;
                    else if (s0_req && s1_req) sel = ~last_grant;
                    else                      sel = s1_req;
                end
            end
            GRANT: begin
                if (m_ack || expired) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Registered bus and requester outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            last_grant <= 1'b1;
            m_req      <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            s0_ack     <= 1'b0;
            s0_rdata   <= '0;
            s0_err     <= 1'b0;
            s1_ack     <= 1'b0;
            s1_rdata   <= '0;
            s1_err     <= 1'b0;
        end else begin
            busy   <= (state_n != IDLE);
            s0_ack <= 1'b0;
            s1_ack <= 1'b0;
            if (grant) begin
                last_grant <= sel;
                m_req      <= 1'b1;
                m_wr       <= sel ? s1_wr    : s0_wr;
                m_addr     <= sel ? s1_addr  : s0_addr;
                m_wdata    <= sel ? s1_wdata : s0_wdata;
            end
            if (done) begin
                m_req <= 1'b0;
                if (last_grant) begin
                    s1_ack   <= 1'b1;
                    s1_rdata <= rsp_data;
                    s1_err   <= rsp_err;
                end else begin
                    s0_ack   <= 1'b1;
                    s0_rdata <= rsp_data;
                    s0_err   <= rsp_err;
                end
            end
        end
    end

endmodule
